// File: rtl/mano_pkg.sv
// Shared constants for the basic-computer control slice: opcodes, decoder
// indices and timing-state indices.
package mano_pkg;

  typedef enum logic [2:0] {
    OP_AND = 3'd0,
    OP_ADD = 3'd1,
    OP_LDA = 3'd2,
    OP_STA = 3'd3,
    OP_BUN = 3'd4,
    OP_BSA = 3'd5,
    OP_ISZ = 3'd6,
    OP_REG = 3'd7
  } opcode_e;

  // Decoder outputs of interest.
  localparam int D_BSA = 5;
  localparam int D_REG = 7;

  // Timing-state indices into the one-hot T vector.
  localparam int T0 = 0;
  localparam int T1 = 1;
  localparam int T2 = 2;
  localparam int T3 = 3;
  localparam int T4 = 4;

  // 3-to-8 one-hot opcode decoder.
  function automatic logic [7:0] decode_op(input opcode_e op);
    return 8'b1 << op;
  endfunction

endpackage

// File: rtl/seq_counter.sv
// Sequence counter: free-running timing-state counter with a clear request.
module seq_counter #(
  parameter int SCW = 4
) (
  input  logic           CLK,
  input  logic           RST_N,
  input  logic           SC_CLR,
  output logic [SCW-1:0] count
);

  // Reset and clear both return to T0; otherwise step and wrap naturally.
  always_ff @(posedge CLK) begin
    if (!RST_N)      count <= '0;
    else if (SC_CLR) count <= '0;
    else             count <= count + SCW'(1);
  end

endmodule

// File: rtl/addr_reg_seq.sv
// Address register with its micro-op decode and the timing sequence counter.
// Strobes are purely combinational from IN_IR, R_FLAG and the current T state;
// the register applies at most one micro-op per edge (clear > load > inc).
// SCW must be at least 3 so that T0..T4 exist.
module addr_reg_seq
  import mano_pkg::*;
#(
  parameter int AW  = 12,
  parameter int DW  = 16,
  parameter int SCW = 4
) (
  input  logic           CLK,
  input  logic           RST_N,
  input  logic [DW-1:0]  IN_IR,
  input  logic [DW-1:0]  IN_BUS,
  input  logic           SC_CLR,
  input  logic           R_FLAG,
  output logic [AW-1:0]  Q_AR,
  output logic [SCW-1:0] T_CNT,
  output logic           LD_AR,
  output logic           INC_AR,
  output logic           CLR_AR,
  output logic           AR_WRAP
);

  localparam int NT = 2**SCW;

  opcode_e       op;
  logic          i_bit;
  logic [7:0]    d;
  logic [NT-1:0] t;

  seq_counter #(.SCW(SCW)) u_sc (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .SC_CLR (SC_CLR),
    .count  (T_CNT)
  );

  // Decode reads IN_IR directly, so an IR change mid-instruction is seen at once.
  assign op    = opcode_e'(IN_IR[DW-2 -: 3]);
  assign i_bit = IN_IR[DW-1];
  assign d     = decode_op(op);
  assign t     = NT'(1) << T_CNT;

  // Micro-op strobes; R_FLAG turns the fetch loads at T0/T2 into an AR clear.
  always_comb begin
    CLR_AR = R_FLAG & t[T0];
    LD_AR  = (~R_FLAG & t[T0]) | (~R_FLAG & t[T2]) | (~d[D_REG] & i_bit & t[T3]);
    INC_AR = d[D_BSA] & t[T4];
  end

  // AR datapath; wrap pulse flags an increment that rolled all-ones to zero.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      Q_AR    <= '0;
      AR_WRAP <= 1'b0;
    end else begin
      AR_WRAP <= 1'b0;
      if (CLR_AR)      Q_AR <= '0;
      else if (LD_AR)  Q_AR <= IN_BUS[AW-1:0];
      else if (INC_AR) begin
        Q_AR    <= Q_AR + AW'(1);
        AR_WRAP <= &Q_AR;
      end
    end
  end

  // Bits of the bus/IR and late timing states this block has no use for.
  logic unused_bits;
  assign unused_bits = ^{IN_BUS[DW-1:AW], IN_IR[DW-5:0], t[NT-1:T4+1], d[6], d[4:0]};

endmodule

// File: tb/tb_addr_reg_seq.sv
// Bench for addr_reg_seq: directed scenarios plus randomized traffic against a
// cycle-level model built from the micro-op equations.
module tb_addr_reg_seq;

  localparam int AW = 12, DW = 16, SCW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0, sc_clr = 1'b0, r_flag = 1'b0;
  logic [DW-1:0] ir = '0, bus = '0;
  logic [AW-1:0] q_ar;
  logic [SCW-1:0] t_cnt;
  logic          ld_ar, inc_ar, clr_ar, ar_wrap;

  // Wide instance for the parameter sweep.
  logic          w_rst_n = 1'b0;
  logic [19:0]   w_ir = '0, w_bus = '0;
  logic [15:0]   w_q;
  logic [3:0]    w_t;
  logic          w_ld, w_inc, w_clr, w_wrap;

  int checks = 0, failures = 0;
  int m_ar = 0, m_t = 0, m_wrap = 0;

  always #5 clk = ~clk;

  addr_reg_seq #(.AW(AW), .DW(DW), .SCW(SCW)) dut (
    .CLK(clk), .RST_N(rst_n), .IN_IR(ir), .IN_BUS(bus), .SC_CLR(sc_clr),
    .R_FLAG(r_flag), .Q_AR(q_ar), .T_CNT(t_cnt), .LD_AR(ld_ar),
    .INC_AR(inc_ar), .CLR_AR(clr_ar), .AR_WRAP(ar_wrap)
  );

  addr_reg_seq #(.AW(16), .DW(20), .SCW(4)) dut_w (
    .CLK(clk), .RST_N(w_rst_n), .IN_IR(w_ir), .IN_BUS(w_bus), .SC_CLR(1'b0),
    .R_FLAG(1'b0), .Q_AR(w_q), .T_CNT(w_t), .LD_AR(w_ld),
    .INC_AR(w_inc), .CLR_AR(w_clr), .AR_WRAP(w_wrap)
  );

  // Expected {clr, ld, inc} for the present model state and inputs.
  function automatic logic [2:0] model_strobes();
    int op = int'(ir[DW-2 -: 3]);
    bit ib = ir[DW-1];
    bit c  = r_flag && m_t == 0;
    bit l  = (!r_flag && (m_t == 0 || m_t == 2)) || (op != 7 && ib && m_t == 3);
    bit n  = (op == 5) && m_t == 4;
    return {c, l, n};
  endfunction

  // One clock edge; the model advances with the DUT, then settle 1 time unit.
  task automatic tick();
    logic [2:0] s;
    @(posedge clk);
    s = model_strobes();
    if (!rst_n) begin
      m_ar = 0; m_t = 0; m_wrap = 0;
    end else begin
      m_wrap = (!s[2] && !s[1] && s[0] && m_ar == 4095) ? 1 : 0;
      if (s[2])      m_ar = 0;
      else if (s[1]) m_ar = int'(bus[AW-1:0]);
      else if (s[0]) m_ar = (m_ar + 1) % 4096;
      m_t = sc_clr ? 0 : (m_t + 1) % 16;
    end
    #1;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0; sc_clr = 1'b0; r_flag = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    checks++;
    if (q_ar !== 12'h000 || t_cnt !== 4'd0 || ar_wrap !== 1'b0) begin
      failures++; $display("FAIL reset_init: Q_AR=%h T_CNT=%0d AR_WRAP=%b need 000/0/0", q_ar, t_cnt, ar_wrap);
    end
    rst_n = 1'b1; bus = 16'h0ABC; #1;
    checks++;
    if ({clr_ar, ld_ar, inc_ar} !== 3'b010) begin
      failures++; $display("FAIL reset_strobe: {clr,ld,inc}=%b need 010", {clr_ar, ld_ar, inc_ar});
    end
    tick();
    // Reset must beat a pending clear request and leave no state behind.
    rst_n = 1'b0; sc_clr = 1'b1; ir = 16'h5000;
    tick();
    checks++;
    if (q_ar !== 12'h000 || t_cnt !== 4'd0 || ar_wrap !== 1'b0) begin
      failures++; $display("FAIL reset_override: Q_AR=%h T_CNT=%0d need 000/0", q_ar, t_cnt);
    end
    sc_clr = 1'b0; ir = '0; rst_n = 1'b1;
  endtask

  task automatic test_fetch();
    reset_dut();
    ir = 16'h0000; bus = 16'h0123; #1;
    checks++;
    if ({clr_ar, ld_ar, inc_ar} !== 3'b010) begin
      failures++; $display("FAIL fetch_t0_strobe: {clr,ld,inc}=%b need 010", {clr_ar, ld_ar, inc_ar});
    end
    tick();
    checks++;
    if (q_ar !== 12'h123 || t_cnt !== 4'd1) begin
      failures++; $display("FAIL fetch_t0: Q_AR=%h T_CNT=%0d need 123/1", q_ar, t_cnt);
    end
    bus = 16'h0FFF;
    tick();
    checks++;
    if (q_ar !== 12'h123) begin
      failures++; $display("FAIL fetch_t1_hold: Q_AR=%h need 123", q_ar);
    end
    bus = 16'h0ABC;
    tick();
    checks++;
    if (q_ar !== 12'hABC || t_cnt !== 4'd3) begin
      failures++; $display("FAIL fetch_t2: Q_AR=%h T_CNT=%0d need ABC/3", q_ar, t_cnt);
    end
  endtask

  task automatic test_indirect();
    logic [15:0] irs [3];
    logic [11:0] exp [3];
    irs[0] = 16'h8000 | 16'($urandom_range(0, 4095));  // I=1, op 000: load
    irs[1] = 16'h0000 | 16'($urandom_range(0, 4095));  // I=0: hold
    irs[2] = 16'hF000 | 16'($urandom_range(0, 4095));  // I=1, op 111: hold
    exp[0] = 12'h777; exp[1] = 12'h222; exp[2] = 12'h222;
    for (int k = 0; k < 3; k++) begin
      reset_dut();
      ir = '0; bus = 16'h0000;
      tick(); tick();
      bus = 16'h0222;
      tick();
      ir = irs[k]; bus = 16'h0777;
      tick();
      checks++;
      if (q_ar !== exp[k]) begin
        failures++; $display("FAIL indirect_%0d: IR=%h Q_AR=%h need %h", k, irs[k], q_ar, exp[k]);
      end
    end
    ir = '0;
  endtask

  task automatic test_bsa_wrap();
    reset_dut();
    ir = 16'h5000; bus = 16'h0FFF;
    tick();
    bus = 16'h0000; tick();
    bus = 16'h0FFF; tick();
    tick();
    checks++;
    if (inc_ar !== 1'b1 || ld_ar !== 1'b0 || t_cnt !== 4'd4) begin
      failures++; $display("FAIL bsa_strobe: inc=%b ld=%b T_CNT=%0d need 1/0/4", inc_ar, ld_ar, t_cnt);
    end
    tick();
    checks++;
    if (q_ar !== 12'h000 || ar_wrap !== 1'b1) begin
      failures++; $display("FAIL bsa_wrap: Q_AR=%h AR_WRAP=%b need 000/1", q_ar, ar_wrap);
    end
    tick();
    checks++;
    if (q_ar !== 12'h000 || ar_wrap !== 1'b0) begin
      failures++; $display("FAIL bsa_wrap_end: Q_AR=%h AR_WRAP=%b need 000/0", q_ar, ar_wrap);
    end
    ir = '0;
  endtask

  task automatic test_interrupt();
    reset_dut();
    ir = 16'h0000; bus = 16'h0555; sc_clr = 1'b1;
    tick();
    sc_clr = 1'b0; r_flag = 1'b1; #1;
    checks++;
    if (q_ar !== 12'h555 || {clr_ar, ld_ar, inc_ar} !== 3'b100) begin
      failures++; $display("FAIL int_t0_strobe: Q_AR=%h {clr,ld,inc}=%b need 555/100", q_ar, {clr_ar, ld_ar, inc_ar});
    end
    tick();
    checks++;
    if (q_ar !== 12'h000) begin
      failures++; $display("FAIL int_clear: Q_AR=%h need 000", q_ar);
    end
    tick();
    bus = 16'h0F0F;
    tick();
    checks++;
    if (q_ar !== 12'h000 || t_cnt !== 4'd3) begin
      failures++; $display("FAIL int_t2_hold: Q_AR=%h T_CNT=%0d need 000/3", q_ar, t_cnt);
    end
    r_flag = 1'b0;
  endtask

  task automatic test_sc_clr();
    logic [11:0] v;
    v = 12'($urandom_range(1, 4095));
    reset_dut();
    ir = 16'hA000 | 16'($urandom_range(0, 4095)); bus = '0;
    tick(); tick(); tick();
    bus = {4'h0, v}; sc_clr = 1'b1;
    tick();
    checks++;
    if (q_ar !== v || t_cnt !== 4'd0) begin
      failures++; $display("FAIL sc_clr_t3: Q_AR=%h T_CNT=%0d need %h/0", q_ar, t_cnt, v);
    end
    sc_clr = 1'b0; ir = '0;
    for (int k = 0; k < 15; k++) tick();
    checks++;
    if (t_cnt !== 4'd15) begin
      failures++; $display("FAIL sc_top: T_CNT=%0d need 15", t_cnt);
    end
    tick();
    checks++;
    if (t_cnt !== 4'd0) begin
      failures++; $display("FAIL sc_wrap: T_CNT=%0d need 0", t_cnt);
    end
  endtask

  task automatic test_reset_mid();
    reset_dut();
    ir = 16'h5000; bus = 16'h0010;
    tick();
    bus = 16'h0000; tick();
    bus = 16'h0010; tick();
    tick();
    rst_n = 1'b0;
    tick();
    checks++;
    if (q_ar !== 12'h000 || t_cnt !== 4'd0 || ar_wrap !== 1'b0) begin
      failures++; $display("FAIL reset_mid: Q_AR=%h T_CNT=%0d AR_WRAP=%b need 000/0/0", q_ar, t_cnt, ar_wrap);
    end
    rst_n = 1'b1; bus = 16'h0BEE; #1;
    checks++;
    if ({clr_ar, ld_ar, inc_ar} !== 3'b010) begin
      failures++; $display("FAIL reset_mid_t0: {clr,ld,inc}=%b need 010", {clr_ar, ld_ar, inc_ar});
    end
    tick();
    checks++;
    if (q_ar !== 12'hBEE || t_cnt !== 4'd1) begin
      failures++; $display("FAIL reset_mid_resume: Q_AR=%h T_CNT=%0d need BEE/1", q_ar, t_cnt);
    end
    ir = '0;
  endtask

  task automatic test_random();
    logic [2:0] s;
    for (int k = 0; k < 600; k++) begin
      rst_n  = ($urandom_range(0, 59) != 0);
      sc_clr = ($urandom_range(0, 11) == 0);
      r_flag = ($urandom_range(0, 3) == 0);
      ir     = 16'($urandom);
      if ($urandom_range(0, 2) == 0) ir[14:12] = 3'b101;
      bus    = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
      #1;
      if (rst_n) begin
        s = model_strobes();
        checks++;
        if ({clr_ar, ld_ar, inc_ar} !== s) begin
          failures++; $display("FAIL rand_strobe[%0d]: {clr,ld,inc}=%b need %b T=%0d", k, {clr_ar, ld_ar, inc_ar}, s, m_t);
        end
      end
      tick();
      checks++;
      if (q_ar !== AW'(m_ar) || t_cnt !== SCW'(m_t) || ar_wrap !== m_wrap[0]) begin
        failures++; $display("FAIL rand_state[%0d]: Q_AR=%h T=%0d W=%b need %h/%0d/%0d", k, q_ar, t_cnt, ar_wrap, m_ar, m_t, m_wrap);
      end
    end
    rst_n = 1'b1; sc_clr = 1'b0; r_flag = 1'b0;
  endtask

  task automatic test_wide();
    w_rst_n = 1'b0;
    tick();
    w_rst_n = 1'b1; w_ir = '0; w_bus = 20'h01234;
    tick();
    checks++;
    if (w_q !== 16'h1234 || w_t !== 4'd1) begin
      failures++; $display("FAIL wide_t0: Q_AR=%h T_CNT=%0d need 1234/1", w_q, w_t);
    end
    w_bus = 20'h0FFFF;
    tick();
    w_bus = 20'h0ABCD;
    tick();
    checks++;
    if (w_q !== 16'hABCD || w_t !== 4'd3 || w_wrap !== 1'b0) begin
      failures++; $display("FAIL wide_t2: Q_AR=%h T_CNT=%0d need ABCD/3", w_q, w_t);
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_indirect();
    test_bsa_wrap();
    test_interrupt();
    test_sc_clr();
    test_reset_mid();
    test_random();
    test_wide();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/addr_reg_seq.md
ADDR_REG_SEQ -- requirements
Module: addr_reg_seq

Interface
REQ-001 SHALL have parameter AW, default 12, meaning address register width.
REQ-002 SHALL have parameter DW, default 16, meaning instruction/bus width; DW >= AW+4.
REQ-003 SHALL have parameter SCW, default 4, meaning sequence-counter width; timing states T0..T(2**SCW-1).
REQ-004 SHALL use one clock; reset is synchronous and active-low.
REQ-005 CLK  in  1  system clock; all state changes on rising edge.
REQ-006 RST_N  in  1  synchronous active-low reset.
REQ-007 IN_IR  in  DW  instruction register; bit DW-1 = I, bits DW-2..DW-4 = opcode.
REQ-008 IN_BUS  in  DW  common bus; AR load source is IN_BUS[AW-1:0].
REQ-009 SC_CLR  in  1  control-unit request to clear sequence counter.
REQ-010 R_FLAG  in  1  interrupt-cycle flag.
REQ-011 Q_AR  out  AW  address register contents.
REQ-012 T_CNT  out  SCW  current sequence-counter value.
REQ-013 LD_AR, INC_AR, CLR_AR  out  1 each  combinational micro-op strobes for the current cycle.
REQ-014 AR_WRAP  out  1  registered one-cycle pulse after an increment wraps Q_AR to zero.

Function
REQ-015 Decode SHALL be combinational: D[7:0] one-hot from IN_IR[DW-2:DW-4], I = IN_IR[DW-1], T one-hot from T_CNT.
REQ-016 CLR_AR SHALL be R_FLAG & T0.
REQ-017 LD_AR SHALL be (~R_FLAG & T0) | (~R_FLAG & T2) | (~D7 & I & T3).
REQ-018 INC_AR SHALL be D5 & T4.
REQ-019 Priority per edge SHALL be CLR_AR > LD_AR > INC_AR; at most one applied.
REQ-020 CLR_AR: Q_AR <= 0 at the edge; LD_AR: Q_AR <= IN_BUS[AW-1:0]; INC_AR: Q_AR <= Q_AR+1 modulo 2**AW; none: hold.
REQ-021 R_FLAG=1 SHALL suppress the T0 and T2 loads; T1/T2 of the interrupt cycle leave Q_AR unchanged.
REQ-022 T_CNT SHALL increment by 1 every cycle, wrapping 2**SCW-1 -> 0.
REQ-023 SC_CLR=1 SHALL force T_CNT to 0 at the next edge; the micro-op decoded in that same cycle still executes.
REQ-024 AR_WRAP SHALL be 1 for exactly the cycle after an INC_AR edge with Q_AR all-ones; 0 otherwise.
REQ-025 Latency: strobe asserted in cycle n -> Q_AR updated at the end of cycle n, visible in cycle n+1.
REQ-026 IN_IR changes mid-instruction SHALL take effect on the decode in the same cycle (no internal IR copy).

Reset
REQ-027 RST_N=0 at an edge SHALL set Q_AR=0, T_CNT=0, AR_WRAP=0, overriding all micro-ops and SC_CLR.
REQ-028 Reset asserted mid-instruction SHALL abandon it; the first cycle after release is T0.
REQ-029 Strobe outputs SHALL follow decode of the reset state (T0) once RST_N=1.

Structure
REQ-030 Shared package mano_pkg SHALL hold opcode constants, D-index localparams (D_BSA=5, D_REG=7), and timing-index localparams T0..T4.
REQ-031 Sequence counter SHALL be a sub-module seq_counter (parameter SCW; inputs CLK, RST_N, SC_CLR; output count).
REQ-032 Decode and AR datapath SHALL reside in addr_reg_seq; no latches, no initial blocks for state.

Verification
REQ-033 Fetch: RST_N pulse, IN_BUS=16'h0123 at T0, 16'h0ABC at T2, R_FLAG=0 -> Q_AR=12'h123 after T0, 12'hABC after T2.
REQ-034 Indirect: IN_IR=16'h8xxx (I=1, opcode 000), IN_BUS=16'h0777 at T3 -> Q_AR=12'h777; same with I=0 -> Q_AR held.
REQ-035 BSA wrap: IN_IR opcode 101, Q_AR=12'hFFF at T4 -> Q_AR=12'h000, AR_WRAP=1 one cycle then 0.
REQ-036 Interrupt: R_FLAG=1 at T0, Q_AR=12'h555 -> Q_AR=0 after T0; T2 with IN_BUS=16'h0F0F -> Q_AR stays 0.
REQ-037 SC_CLR at T3 with I=1, opcode 010 -> load executes, T_CNT=0 next cycle; T_CNT wraps 15->0 when SC_CLR never asserted.
REQ-038 Reset at T4 during BSA with Q_AR=12'h010 -> Q_AR=0, T_CNT=0, no increment; sweep AW=16, DW=20 repeating REQ-033.
